// File: rtl/dramw_arbiter_pkg.sv
// Shared types for the DRAM write path.
//   GLOBAL_ADDR_BW / DATA_BW / CACHE_SIZE : default channel geometry
//   id_bw()      : width of a requester index (at least 1 bit)
//   dramw_beat_t : one write beat {addr, data, mask} at default geometry
package dramw_arbiter_pkg;
  localparam int GLOBAL_ADDR_BW = 32;
  localparam int DATA_BW        = 32;
  localparam int CACHE_SIZE     = 8;

  function automatic int id_bw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [GLOBAL_ADDR_BW-1:0]             addr;
    logic [CACHE_SIZE-1:0][DATA_BW-1:0]    data;
    logic [CACHE_SIZE-1:0]                 mask;
  } dramw_beat_t;
endpackage

// File: rtl/dramw_arbiter_if.sv
// Bus bundle between N_REQ write producers, the arbiter and the DRAM write port.
//   requester side : i_req_rdy/i_req_ack handshake plus a/d/mask payload per lane
//   dram side      : dramw_rdy/dramw_ack handshake plus addr/data/mask/src
//   slave  : arbiter view
//   master : producer + DRAM-port view (drives requests, consumes beats)
interface dramw_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int GBW   = 32,
  parameter int DBW   = 32,
  parameter int CSIZE = 8,
  parameter int ID_BW = 1
);
  logic [N_REQ-1:0]                       i_req_rdy;
  logic [N_REQ-1:0]                       i_req_ack;
  logic [N_REQ-1:0][GBW-1:0]              i_req_a;
  logic [N_REQ-1:0][CSIZE-1:0][DBW-1:0]   i_req_d;
  logic [N_REQ-1:0][CSIZE-1:0]            i_req_mask;
  logic                                   dramw_rdy;
  logic                                   dramw_ack;
  logic [GBW-1:0]                         o_dramwa;
  logic [CSIZE-1:0][DBW-1:0]              o_dramwd;
  logic [CSIZE-1:0]                       o_dramw_mask;
  logic [ID_BW-1:0]                       o_dramw_src;

  modport slave (
    input  i_req_rdy, i_req_a, i_req_d, i_req_mask, dramw_ack,
    output i_req_ack, dramw_rdy, o_dramwa, o_dramwd, o_dramw_mask, o_dramw_src
  );
  modport master (
    output i_req_rdy, i_req_a, i_req_d, i_req_mask, dramw_ack,
    input  i_req_ack, dramw_rdy, o_dramwa, o_dramwd, o_dramw_mask, o_dramw_src
  );
endinterface

// File: rtl/rr_pick_n.sv
// Combinational round-robin priority picker.
//   req : request vector
//   ptr : highest-priority index this cycle (must be < N)
//   gnt : one-hot grant, idx : grant index, any : some request present
module rr_pick_n #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Scan from farthest to nearest offset so the nearest hit to ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IW'(j);
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dramw_arbiter.sv
// Round-robin arbiter sharing one DRAM write channel among N_REQ producers.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : per-requester rdy/ack + payload in; registered dramw beat out
// One output register slice; a draining slot reloads in the same cycle.
// With DROP_EMPTY=1, beats with an all-zero mask are acked and discarded.
module dramw_arbiter
  import dramw_arbiter_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int GBW        = GLOBAL_ADDR_BW,
  parameter int DBW        = DATA_BW,
  parameter int CSIZE      = CACHE_SIZE,
  parameter int DROP_EMPTY = 1,
  parameter int ID_BW      = id_bw(N_REQ)
) (
  input logic          i_clk,
  input logic          i_rst,
  dramw_arbiter_if.slave bus
);
  // Same layout as dramw_beat_t, sized by this instance's parameters.
  typedef struct packed {
    logic [GBW-1:0]            addr;
    logic [CSIZE-1:0][DBW-1:0] data;
    logic [CSIZE-1:0]          mask;
  } beat_t;

  beat_t             beat_q;
  logic              vld_q;
  logic [ID_BW-1:0]  src_q;
  logic [ID_BW-1:0]  ptr;
  logic [ID_BW-1:0]  ptr_nxt;
  logic [N_REQ-1:0]  gnt;
  logic [ID_BW-1:0]  g;
  logic              any;
  logic              can_load, empty, take, load;

  rr_pick_n #(.N(N_REQ), .IW(ID_BW)) u_pick (
    .req (bus.i_req_rdy),
    .ptr (ptr),
    .gnt (gnt),
    .idx (g),
    .any (any)
  );

  assign can_load = !vld_q || bus.dramw_ack;
  assign empty    = (DROP_EMPTY != 0) && (bus.i_req_mask[g] == '0);
  // Empty beats are acked even into a full slot: they never occupy it.
  assign take     = !i_rst && any && (can_load || empty);
  assign load     = take && !empty;
  // Explicit wrap so non-power-of-two N_REQ never reaches an unused index.
  assign ptr_nxt  = (g == ID_BW'(N_REQ - 1)) ? '0 : g + 1'b1;

  assign bus.i_req_ack    = take ? gnt : '0;
  assign bus.dramw_rdy    = vld_q;
  assign bus.o_dramwa     = beat_q.addr;
  assign bus.o_dramwd     = beat_q.data;
  assign bus.o_dramw_mask = beat_q.mask;
  assign bus.o_dramw_src  = src_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_q  <= 1'b0;
      beat_q <= '0;
      src_q  <= '0;
      ptr    <= '0;
    end else begin
      if (take) ptr <= ptr_nxt;
      if (load) begin
        vld_q       <= 1'b1;
        beat_q.addr <= bus.i_req_a[g];
        beat_q.data <= bus.i_req_d[g];
        beat_q.mask <= bus.i_req_mask[g];
        src_q       <= g;
      end else if (bus.dramw_ack) begin
        vld_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dramw_arbiter.sv
module tb_dramw_arbiter;
  localparam int GBW = 16, DBW = 8, CS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  dramw_arbiter_if #(.N_REQ(2), .GBW(GBW), .DBW(DBW), .CSIZE(CS), .ID_BW(1)) if0 ();
  dramw_arbiter_if #(.N_REQ(3), .GBW(GBW), .DBW(DBW), .CSIZE(CS), .ID_BW(2)) if1 ();
  dramw_arbiter_if #(.N_REQ(2), .GBW(GBW), .DBW(DBW), .CSIZE(CS), .ID_BW(1)) if2 ();

  dramw_arbiter #(.N_REQ(2), .GBW(GBW), .DBW(DBW), .CSIZE(CS), .DROP_EMPTY(1)) u0 (
    .i_clk(clk), .i_rst(rst), .bus(if0));
  dramw_arbiter #(.N_REQ(3), .GBW(GBW), .DBW(DBW), .CSIZE(CS), .DROP_EMPTY(1)) u1 (
    .i_clk(clk), .i_rst(rst), .bus(if1));
  dramw_arbiter #(.N_REQ(2), .GBW(GBW), .DBW(DBW), .CSIZE(CS), .DROP_EMPTY(0)) u2 (
    .i_clk(clk), .i_rst(rst), .bus(if2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dat(input logic [15:0] a);
    return {a[7:0] ^ 8'h5a, a[7:0]};
  endfunction

  task automatic d0(input int r, input logic v, input logic [15:0] a, input logic [1:0] m);
    if0.i_req_rdy[r] = v; if0.i_req_a[r] = a; if0.i_req_d[r] = dat(a); if0.i_req_mask[r] = m;
  endtask
  task automatic d1(input int r, input logic v, input logic [15:0] a, input logic [1:0] m);
    if1.i_req_rdy[r] = v; if1.i_req_a[r] = a; if1.i_req_d[r] = dat(a); if1.i_req_mask[r] = m;
  endtask
  task automatic d2(input int r, input logic v, input logic [15:0] a, input logic [1:0] m);
    if2.i_req_rdy[r] = v; if2.i_req_a[r] = a; if2.i_req_d[r] = dat(a); if2.i_req_mask[r] = m;
  endtask

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk);     endtask

  initial begin
    int ga, gb, ng, wait_g;
    logic r2done;
    if0.i_req_rdy = '0; if0.i_req_a = '0; if0.i_req_d = '0; if0.i_req_mask = '0; if0.dramw_ack = 1'b0;
    if1.i_req_rdy = '0; if1.i_req_a = '0; if1.i_req_d = '0; if1.i_req_mask = '0; if1.dramw_ack = 1'b0;
    if2.i_req_rdy = '0; if2.i_req_a = '0; if2.i_req_d = '0; if2.i_req_mask = '0; if2.dramw_ack = 1'b0;

    // ---- reset: no ack while held, outputs cleared
    d0(0, 1'b1, 16'h0010, 2'b11);
    #3;
    chk("rst_ack_held", if0.i_req_ack, 0);
    d0(0, 1'b0, 16'h0010, 2'b11);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_rdy", if0.dramw_rdy, 0);
    chk("rst_addr", if0.o_dramwa, 0);
    chk("rst_data", if0.o_dramwd, 0);
    chk("rst_mask", if0.o_dramw_mask, 0);
    chk("rst_src", if0.o_dramw_src, 0);
    chk("rst_ptr", u0.ptr, 0);

    // load one beat, then hit reset mid-cycle
    tick(); d0(0, 1'b1, 16'h0010, 2'b11); if0.dramw_ack = 1'b0;
    mid();  chk("pre_rst_ack", if0.i_req_ack, 1);
    tick(); d0(0, 1'b0, 16'h0010, 2'b11);
    chk("pre_rst_rdy", if0.dramw_rdy, 1);
    chk("pre_rst_addr", if0.o_dramwa, 16'h0010);
    #2 rst = 1'b1; d0(1, 1'b1, 16'h0020, 2'b11);
    #1;
    chk("async_rst_rdy", if0.dramw_rdy, 0);
    chk("async_rst_addr", if0.o_dramwa, 0);
    chk("async_rst_ack", if0.i_req_ack, 0);
    d0(1, 1'b0, 16'h0020, 2'b11);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("post_rst_ptr", u0.ptr, 0);
    chk("post_rst_src", if0.o_dramw_src, 0);

    // ---- round robin under saturation: A0..A2 / B0..B1
    ga = 0; gb = 0; if0.dramw_ack = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      d0(0, ga < 3, 16'(16'h0100 + ga), 2'b11);
      d0(1, gb < 2, 16'(16'h0200 + gb), 2'b11);
      mid();
      if (k < 5) chk($sformatf("sat_ack%0d", k), if0.i_req_ack, (k % 2 == 0) ? 1 : 2);
      if (k >= 1 && k <= 5) begin
        chk($sformatf("sat_rdy%0d", k), if0.dramw_rdy, 1);
        chk($sformatf("sat_src%0d", k), if0.o_dramw_src, (k - 1) % 2);
        chk($sformatf("sat_addr%0d", k), if0.o_dramwa,
            (((k - 1) % 2 == 0) ? 32'h0100 : 32'h0200) + (k - 1) / 2);
      end
      if (k == 1) chk("sat_data1", if0.o_dramwd, dat(16'h0100));
      if (k == 6) chk("sat_drained", if0.dramw_rdy, 0);
      if (k < 5) begin if (k % 2 == 0) ga++; else gb++; end
    end

    // ---- backpressure: ptr=1 so req1 loads first, then stall 5 cycles
    for (int k = 0; k < 8; k++) begin
      tick();
      d0(0, k <= 6, 16'h0300, 2'b11);
      d0(1, k == 0, 16'h0400, 2'b11);
      if0.dramw_ack = (k == 6);
      mid();
      if (k == 0) begin
        chk("bp_ack0", if0.i_req_ack, 2);
        chk("bp_rdy0", if0.dramw_rdy, 0);
      end
      if (k >= 1 && k <= 5) begin
        chk($sformatf("bp_ack%0d", k), if0.i_req_ack, 0);
        chk($sformatf("bp_rdy%0d", k), if0.dramw_rdy, 1);
        chk($sformatf("bp_addr%0d", k), if0.o_dramwa, 16'h0400);
      end
      if (k == 6) begin
        chk("bp_reload_ack", if0.i_req_ack, 1);
        chk("bp_drain_addr", if0.o_dramwa, 16'h0400);
      end
      if (k == 7) begin
        chk("bp_next_addr", if0.o_dramwa, 16'h0300);
        chk("bp_next_src", if0.o_dramw_src, 0);
        chk("bp_next_rdy", if0.dramw_rdy, 1);
      end
    end

    // ---- empty-mask drop while slot full and stalled
    for (int k = 0; k < 4; k++) begin
      tick();
      d0(0, k == 0, 16'h0040, 2'b00);
      if0.dramw_ack = (k == 2);
      mid();
      if (k == 0) chk("drop_ack", if0.i_req_ack, 1);
      if (k == 1) begin
        chk("drop_ptr", u0.ptr, 1);
        chk("drop_rdy", if0.dramw_rdy, 1);
      end
      if (k <= 2) chk($sformatf("drop_hold%0d", k), if0.o_dramwa, 16'h0300);
      if (k == 3) begin
        chk("drop_gone_rdy", if0.dramw_rdy, 0);
        chk("drop_gone_addr", if0.o_dramwa, 16'h0300);
      end
    end

    // ---- DROP_EMPTY=0: empty beat waits, then forwarded with mask 0
    for (int k = 0; k < 5; k++) begin
      tick();
      d2(1, k == 0, 16'h0050, 2'b11);
      d2(0, k >= 1 && k <= 3, 16'h0040, 2'b00);
      if2.dramw_ack = (k == 3);
      mid();
      if (k == 0) chk("keep_ack0", if2.i_req_ack, 2);
      if (k == 1 || k == 2) begin
        chk($sformatf("keep_wait%0d", k), if2.i_req_ack, 0);
        chk($sformatf("keep_addr%0d", k), if2.o_dramwa, 16'h0050);
      end
      if (k == 3) chk("keep_ack3", if2.i_req_ack, 1);
      if (k == 4) begin
        chk("keep_fwd_addr", if2.o_dramwa, 16'h0040);
        chk("keep_fwd_mask", if2.o_dramw_mask, 0);
        chk("keep_fwd_src", if2.o_dramw_src, 0);
        chk("keep_fwd_rdy", if2.dramw_rdy, 1);
      end
    end

    // ---- N_REQ=3, only req2: back-to-back, ptr wraps to 0
    if1.dramw_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      d1(2, k < 4, 16'(16'h0500 + k), 2'b11);
      mid();
      if (k < 4) chk($sformatf("one_ack%0d", k), if1.i_req_ack, 4);
      if (k >= 1) begin
        chk($sformatf("one_addr%0d", k), if1.o_dramwa, 16'h0500 + k - 1);
        chk($sformatf("one_src%0d", k), if1.o_dramw_src, 2);
        chk($sformatf("one_ptr%0d", k), u1.ptr, 0);
      end
    end

    // ---- fairness: req0 always on, req2 joins at cycle 10
    r2done = 1'b0; ng = 0; wait_g = 99;
    for (int k = 0; k < 14; k++) begin
      tick();
      d1(0, 1'b1, 16'h0600, 2'b11);
      d1(2, (k >= 10) && !r2done, 16'h0700, 2'b11);
      mid();
      if (k < 10) chk($sformatf("fair_ack%0d", k), if1.i_req_ack, 1);
      if (k == 10) chk("fair_ack10", if1.i_req_ack, 4);
      if (k == 11) chk("fair_ack11", if1.i_req_ack, 1);
      if (k >= 10 && !r2done && if1.i_req_ack != 0) begin
        ng++;
        if (if1.i_req_ack[2]) begin r2done = 1'b1; wait_g = ng; end
      end
    end
    chk("fair_within_3", (wait_g <= 3) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
